// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator
// Brief    : Sums N consecutive 8-bit multiplier products into one result,
//            with valid/ready handshakes on both the input and the output.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
  parameter int N     = 4,
  parameter int CNT_W = 2,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       z,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam logic [0:0] c_st_accum = 1'b0;
  localparam logic [0:0] c_st_done  = 1'b1;

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_sum;

  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_acc_next;

  assign in_ready   = (r_state == c_st_accum);
  assign out_valid  = (r_state == c_st_done);
  assign sum        = r_sum;
  assign count      = r_count;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_count == CNT_W'(N - 1));
  assign w_acc_next = r_acc + ACC_W'(z);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_accum;
      r_acc   <= '0;
      r_count <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        c_st_accum: begin
          // clr has priority over a coinciding term, which is then dropped
          if (clr) begin
            r_acc   <= '0;
            r_count <= '0;
          end else if (w_accept) begin
            if (w_last) begin
              r_sum   <= w_acc_next;
              r_acc   <= '0;
              r_count <= '0;
              r_state <= c_st_done;
            end else begin
              r_acc   <= w_acc_next;
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_accum;
          end
        end
        default: r_state <= c_st_accum;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accumulator
// Brief    : Scoreboard bench for mac_accumulator (N=4 and N=1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] z = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       clr = 1'b0;
  logic [9:0] sum;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] count;

  logic [7:0] z1 = '0;
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic       clr1 = 1'b0;
  logic [7:0] sum1;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [0:0] count1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int q  [$];
  int q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_accumulator #(.N(4), .CNT_W(2), .ACC_W(10)) dut (
    .clk(clk), .rst(rst), .z(z), .in_valid(in_valid), .in_ready(in_ready),
    .clr(clr), .sum(sum), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  mac_accumulator #(.N(1), .CNT_W(1), .ACC_W(8)) dut1 (
    .clk(clk), .rst(rst), .z(z1), .in_valid(in_valid1), .in_ready(in_ready1),
    .clr(clr1), .sum(sum1), .out_valid(out_valid1), .out_ready(out_ready1),
    .count(count1)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitors: every consumed result must match the head of its queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_result", int'(sum), -1);
      else check("result", int'(sum), q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("unexpected_result_n1", int'(sum1), -1);
      else check("result_n1", int'(sum1), q1.pop_front());
    end
  end

  // Holds z/in_valid until a handshake edge has passed; returns at edge+1
  task automatic send(input logic [7:0] v);
    bit ok = 1'b0;
    z = v;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic send1(input logic [7:0] v, output int at);
    bit ok = 1'b0;
    z1 = v;
    in_valid1 = 1'b1;
    at = -1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready1;
      @(posedge clk);
      #1;
    end
    at = cyc;
    if (!ok) check("send1_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t0, t1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_sum", int'(sum), 0);
    idle(1);

    // Basic frame with latency-1 result and one-cycle pulse
    out_ready = 1'b1;
    q.push_back(900);
    for (int i = 0; i < 4; i++) send(8'd225);
    in_valid = 1'b0;
    @(negedge clk);
    check("basic_out_valid", int'(out_valid), 1);
    check("basic_sum", int'(sum), 900);
    @(negedge clk);
    check("basic_valid_drop", int'(out_valid), 0);
    check("basic_in_ready", int'(in_ready), 1);
    idle(1);

    // Back-pressure: result held, no term accepted
    out_ready = 1'b0;
    q.push_back(100);
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    z = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_sum", int'(sum), 100);
      check("bp_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(1);
    @(negedge clk);
    check("bp_count_restart", int'(count), 0);
    check("bp_ready_restart", int'(in_ready), 1);
    idle(1);

    // Gapped input: count moves only on handshakes
    q.push_back(10);
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
      in_valid = 1'b0;
      @(negedge clk);
      check("gap_count", int'(count), i % 4);
      idle(1);
    end
    idle(2);

    // clr mid-frame drops the coinciding term; clr in DONE is ignored
    out_ready = 1'b0;
    q.push_back(10);
    send(8'd50); send(8'd60);
    z = 8'd70;
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_count", int'(count), 0);
    idle(1);
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    in_valid = 1'b0;
    clr = 1'b1;
    idle(2);
    clr = 1'b0;
    @(negedge clk);
    check("clr_done_valid", int'(out_valid), 1);
    check("clr_done_sum", int'(sum), 10);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(2);

    // Asynchronous reset between edges mid-frame
    send(8'd7); send(8'd8);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_count", int'(count), 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_sum", int'(sum), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_valid", int'(out_valid), 0);
    #1;
    rst = 1'b0;
    idle(1);
    q.push_back(20);
    for (int i = 0; i < 4; i++) send(8'd5);
    in_valid = 1'b0;
    idle(3);

    // N=1 build: each accept completes immediately, one bubble between
    q1.push_back(200);
    q1.push_back(7);
    send1(8'd200, t0);
    @(negedge clk);
    check("n1_sum_a", int'(sum1), 200);
    check("n1_count", int'(count1), 0);
    send1(8'd7, t1);
    in_valid1 = 1'b0;
    check("n1_bubble", t1 - t0, 2);
    @(negedge clk);
    check("n1_sum_b", int'(sum1), 7);
    idle(3);

    check("queue_drained", q.size(), 0);
    check("queue1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
